// File: rtl/hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package hazard_ctrl_pkg;

  typedef enum logic [1:0] {
    StRun,
    StMemWait,
    StErr
  } state_e;

  localparam logic [1:0] FWD_NONE = 2'b00;
  localparam logic [1:0] FWD_EXE  = 2'b01;
  localparam logic [1:0] FWD_MEM  = 2'b10;

  localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/hazard_ctrl_if.sv
// Pipeline-to-controller bundle: register usage, memory handshake in; stage controls out.
interface hazard_ctrl_if #(
  parameter int unsigned STALL_CNT_W = 16
);
  logic [4:0]             id_src1;
  logic [4:0]             id_src2;
  logic                   id_src2_used;
  logic [4:0]             exe_dest;
  logic                   exe_wb_en;
  logic                   exe_mem_r_en;
  logic [4:0]             mem_dest;
  logic                   mem_wb_en;
  logic                   br_taken;
  logic                   mem_req;
  logic                   mem_ready;
  logic                   pc_en;
  logic                   ifid_en;
  logic                   ifid_flush;
  logic                   idex_bubble;
  logic                   back_en;
  logic                   mem_err;
  logic [STALL_CNT_W-1:0] stall_cnt;
  logic [1:0]             fwd_a;
  logic [1:0]             fwd_b;

  modport master (
    output id_src1, id_src2, id_src2_used, exe_dest, exe_wb_en, exe_mem_r_en,
           mem_dest, mem_wb_en, br_taken, mem_req, mem_ready,
    input  pc_en, ifid_en, ifid_flush, idex_bubble, back_en, mem_err, stall_cnt,
           fwd_a, fwd_b
  );

  modport slave (
    input  id_src1, id_src2, id_src2_used, exe_dest, exe_wb_en, exe_mem_r_en,
           mem_dest, mem_wb_en, br_taken, mem_req, mem_ready,
    output pc_en, ifid_en, ifid_flush, idex_bubble, back_en, mem_err, stall_cnt,
           fwd_a, fwd_b
  );

endinterface

// File: rtl/hazard_cmp.sv
// Destination-vs-source match for one pipeline stage and one operand; $0 never matches.
module hazard_cmp
  import hazard_ctrl_pkg::*;
(
  input  logic       wb_en,
  input  logic [4:0] dest,
  input  logic [4:0] src,
  input  logic       src_used,
  output logic       match
);

  assign match = wb_en & src_used & (dest == src) & (dest != REG_ZERO);

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: stalls, flushes, memory-wait freeze and timeout error.
// Optional HAZARD_CTRL_FORWARDING_EN: only load-use stalls, registered fwd_a/fwd_b selects.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 64,
  parameter int unsigned STALL_CNT_W = 16
) (
  input  logic        clk,
  input  logic        rst,
  hazard_ctrl_if.slave bus
);

  localparam logic [15:0] TimeoutCnt = 16'(MEM_TIMEOUT);

  state_e                 state_q, state_d;
  logic [15:0]            wait_q, wait_d;
  logic [STALL_CNT_W-1:0] stall_q;
  logic                   mem_err_q;
  logic                   exe_a, exe_b, mem_a, mem_b;
  logic                   raw_hazard, run_rules;
  logic                   pc_en, ifid_en, ifid_flush, idex_bubble, back_en;

  hazard_cmp u_cmp_exe_a (.wb_en(bus.exe_wb_en), .dest(bus.exe_dest), .src(bus.id_src1),
                          .src_used(1'b1), .match(exe_a));
  hazard_cmp u_cmp_exe_b (.wb_en(bus.exe_wb_en), .dest(bus.exe_dest), .src(bus.id_src2),
                          .src_used(bus.id_src2_used), .match(exe_b));
  hazard_cmp u_cmp_mem_a (.wb_en(bus.mem_wb_en), .dest(bus.mem_dest), .src(bus.id_src1),
                          .src_used(1'b1), .match(mem_a));
  hazard_cmp u_cmp_mem_b (.wb_en(bus.mem_wb_en), .dest(bus.mem_dest), .src(bus.id_src2),
                          .src_used(bus.id_src2_used), .match(mem_b));

`ifdef HAZARD_CTRL_FORWARDING_EN
  assign raw_hazard = (exe_a | exe_b) & bus.exe_mem_r_en;
`else
  logic unused_load_flag;
  assign unused_load_flag = bus.exe_mem_r_en;
  assign raw_hazard       = exe_a | exe_b | mem_a | mem_b;
`endif

  always_comb begin
    state_d     = state_q;
    wait_d      = wait_q;
    run_rules   = 1'b0;
    pc_en       = 1'b0;
    ifid_en     = 1'b0;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    back_en     = 1'b0;
    unique case (state_q)
      StRun: begin
        if (bus.mem_req && !bus.mem_ready) begin
          state_d = StMemWait;
          wait_d  = 16'd1;
        end else begin
          run_rules = 1'b1;
        end
      end
      StMemWait: begin
        // The exit cycle is a normal RUN cycle, so a branch parked in EXE is taken now.
        if (bus.mem_ready) begin
          state_d   = StRun;
          wait_d    = 16'd0;
          run_rules = 1'b1;
        end else if (wait_q >= TimeoutCnt) begin
          state_d = StErr;
        end else begin
          wait_d = wait_q + 16'd1;
        end
      end
      StErr: ;
      default: state_d = StRun;
    endcase

    if (run_rules) begin
      if (bus.br_taken) begin
        {pc_en, ifid_en, back_en, ifid_flush, idex_bubble} = 5'b11111;
      end else if (raw_hazard) begin
        back_en     = 1'b1;
        idex_bubble = 1'b1;
      end else begin
        {pc_en, ifid_en, back_en} = 3'b111;
      end
    end

    if (!rst) begin
      {pc_en, ifid_en, back_en} = 3'b000;
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= StRun;
      wait_q    <= 16'd0;
      stall_q   <= '0;
      mem_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      mem_err_q <= mem_err_q | (state_d == StErr);
      if (!pc_en && (stall_q != '1)) begin
        stall_q <= stall_q + STALL_CNT_W'(1);
      end
    end
  end

`ifdef HAZARD_CTRL_FORWARDING_EN
  logic [1:0] fwd_a_q, fwd_b_q, fwd_a_d, fwd_b_d;

  always_comb begin
    fwd_a_d = FWD_NONE;
    fwd_b_d = FWD_NONE;
    if (!idex_bubble) begin
      if (exe_a && !bus.exe_mem_r_en) fwd_a_d = FWD_EXE;
      else if (mem_a)                 fwd_a_d = FWD_MEM;
      if (exe_b && !bus.exe_mem_r_en) fwd_b_d = FWD_EXE;
      else if (mem_b)                 fwd_b_d = FWD_MEM;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fwd_a_q <= FWD_NONE;
      fwd_b_q <= FWD_NONE;
    end else if (back_en) begin
      fwd_a_q <= fwd_a_d;
      fwd_b_q <= fwd_b_d;
    end
  end

  assign bus.fwd_a = fwd_a_q;
  assign bus.fwd_b = fwd_b_q;
`else
  assign bus.fwd_a = FWD_NONE;
  assign bus.fwd_b = FWD_NONE;
`endif

  assign bus.pc_en       = pc_en;
  assign bus.ifid_en     = ifid_en;
  assign bus.ifid_flush  = ifid_flush;
  assign bus.idex_bubble = idex_bubble;
  assign bus.back_en     = back_en;
  assign bus.mem_err     = mem_err_q;
  assign bus.stall_cnt   = stall_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: vector table plus hand sequences, scoreboard-compared.
module tb_hazard_ctrl;

  // {pc_en, ifid_en, ifid_flush, idex_bubble, back_en}
  localparam logic [4:0] C_RUN = 5'b11001;
  localparam logic [4:0] C_RAW = 5'b00011;
  localparam logic [4:0] C_BR  = 5'b11111;
  localparam logic [4:0] C_FRZ = 5'b00000;
  localparam logic [4:0] C_RST = 5'b00110;
`ifdef HAZARD_CTRL_FORWARDING_EN
  localparam logic [4:0] C_ALU = C_RUN;
  localparam logic [1:0] F_EXE = 2'b01;
  localparam logic [1:0] F_MEM = 2'b10;
`else
  localparam logic [4:0] C_ALU = C_RAW;
  localparam logic [1:0] F_EXE = 2'b00;
  localparam logic [1:0] F_MEM = 2'b00;
`endif

  typedef struct packed {
    logic [4:0] src1;
    logic [4:0] src2;
    logic       src2_used;
    logic [4:0] exe_dest;
    logic       exe_wb;
    logic       exe_mr;
    logic [4:0] mem_dest;
    logic       mem_wb;
    logic       br;
    logic       req;
    logic       rdy;
  } in_t;

  typedef struct packed {
    logic [4:0] ctrl;
    logic       mem_err;
    logic       chk_fwd;
    logic [1:0] fwd_a;
  } exp_t;

  typedef struct {
    string      name;
    in_t        i;
    logic [4:0] ctrl;
  } vec_t;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  int   exp_stall;
  exp_t exp_q[$];
  vec_t tbl[9];

  hazard_ctrl_if #(.STALL_CNT_W(16)) bus ();

  hazard_ctrl #(.MEM_TIMEOUT(4), .STALL_CNT_W(16)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic in_t mk(input logic [4:0] s1, input logic [4:0] s2, input logic u2,
                             input logic [4:0] ed, input logic ew, input logic em,
                             input logic [4:0] md, input logic mw, input logic br,
                             input logic req, input logic rdy);
    in_t r;
    r = '{src1: s1, src2: s2, src2_used: u2, exe_dest: ed, exe_wb: ew, exe_mr: em,
          mem_dest: md, mem_wb: mw, br: br, req: req, rdy: rdy};
    return r;
  endfunction

  function automatic exp_t ex(input logic [4:0] c, input logic me, input logic cf,
                              input logic [1:0] fa);
    exp_t r;
    r = '{ctrl: c, mem_err: me, chk_fwd: cf, fwd_a: fa};
    return r;
  endfunction

  task automatic apply(input in_t i);
    bus.id_src1      = i.src1;
    bus.id_src2      = i.src2;
    bus.id_src2_used = i.src2_used;
    bus.exe_dest     = i.exe_dest;
    bus.exe_wb_en    = i.exe_wb;
    bus.exe_mem_r_en = i.exe_mr;
    bus.mem_dest     = i.mem_dest;
    bus.mem_wb_en    = i.mem_wb;
    bus.br_taken     = i.br;
    bus.mem_req      = i.req;
    bus.mem_ready    = i.rdy;
  endtask

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, req, $time);
    end
  endtask

  task automatic set_vec(input int k, input string nm, input in_t i, input logic [4:0] c);
    tbl[k].name = nm;
    tbl[k].i    = i;
    tbl[k].ctrl = c;
  endtask

  // Entered just after a posedge; returns just after the next posedge.
  task automatic step(input string nm, input in_t i, input exp_t e);
    exp_t got;
    apply(i);
    exp_q.push_back(e);
    @(negedge clk);
    got = exp_q.pop_front();
    chk({nm, " ctrl"}, 16'({bus.pc_en, bus.ifid_en, bus.ifid_flush, bus.idex_bubble,
                            bus.back_en}), 16'(got.ctrl));
    chk({nm, " mem_err"}, 16'(bus.mem_err), 16'(got.mem_err));
    chk({nm, " stall_cnt"}, bus.stall_cnt, 16'(exp_stall));
    if (got.chk_fwd) chk({nm, " fwd_a"}, 16'(bus.fwd_a), 16'(got.fwd_a));
    if (!got.ctrl[4]) exp_stall++;
    @(posedge clk);
    #1;
  endtask

  task automatic reset_check(input string nm);
    rst = 1'b0;
    #1;
    chk({nm, " ctrl"}, 16'({bus.pc_en, bus.ifid_en, bus.ifid_flush, bus.idex_bubble,
                            bus.back_en}), 16'(C_RST));
    chk({nm, " stall_cnt"}, bus.stall_cnt, 16'd0);
    chk({nm, " mem_err"}, 16'(bus.mem_err), 16'd0);
    chk({nm, " fwd"}, 16'({bus.fwd_a, bus.fwd_b}), 16'd0);
    exp_stall = 0;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    in_t idle, ld, req_br, req_br_rdy, req_only;
    checks    = 0;
    errors    = 0;
    exp_stall = 0;
    rst       = 1'b0;
    idle      = mk(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    apply(idle);

    set_vec(0, "idle",          idle,                                                C_RUN);
    set_vec(1, "exe_alu_src1",  mk(5, 0, 0, 5, 1, 0, 0, 0, 0, 0, 0),                 C_ALU);
    set_vec(2, "zero_reg",      mk(0, 0, 1, 0, 1, 0, 0, 1, 0, 0, 0),                 C_RUN);
    set_vec(3, "mem_src2_used", mk(1, 7, 1, 2, 1, 0, 7, 1, 0, 0, 0),                 C_ALU);
    set_vec(4, "mem_src2_idle", mk(1, 7, 0, 2, 1, 0, 7, 1, 0, 0, 0),                 C_RUN);
    set_vec(5, "load_src1",     mk(3, 4, 1, 3, 1, 1, 0, 0, 0, 0, 0),                 C_RAW);
    set_vec(6, "branch_wins",   mk(5, 0, 0, 5, 1, 1, 0, 0, 1, 0, 0),                 C_BR);
    set_vec(7, "exe_no_wb",     mk(5, 5, 1, 5, 0, 0, 6, 1, 0, 0, 0),                 C_RUN);
    set_vec(8, "load_src2",     mk(1, 9, 1, 9, 1, 1, 0, 0, 0, 0, 0),                 C_RAW);

    #2;
    chk("reset ctrl", 16'({bus.pc_en, bus.ifid_en, bus.ifid_flush, bus.idex_bubble,
                           bus.back_en}), 16'(C_RST));
    chk("reset stall_cnt", bus.stall_cnt, 16'd0);
    chk("reset mem_err", 16'(bus.mem_err), 16'd0);
    chk("reset fwd", 16'({bus.fwd_a, bus.fwd_b}), 16'd0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;

    // ALU result in EXE, then in MEM, then retired.
    step("raw1", mk(5, 0, 0, 5, 1, 0, 0, 0, 0, 0, 0), ex(C_ALU, 0, 1, 2'b00));
    step("raw2", mk(5, 0, 0, 0, 0, 0, 5, 1, 0, 0, 0), ex(C_ALU, 0, 1, F_EXE));
    step("raw3", mk(5, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), ex(C_RUN, 0, 1, F_MEM));

    // Load-use: one bubble with forwarding, then forward from MEM/WB.
    ld = mk(5, 0, 0, 5, 1, 1, 0, 0, 0, 0, 0);
    step("lu1", ld, ex(C_RAW, 0, 1, 2'b00));
    step("lu2", mk(5, 0, 0, 0, 0, 0, 5, 1, 0, 0, 0), ex(C_ALU, 0, 1, 2'b00));
    step("lu3", mk(5, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), ex(C_RUN, 0, 1, F_MEM));

    // Memory wait with a taken branch parked in EXE.
    req_br     = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0);
    req_br_rdy = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1);
    step("mw_run", req_br, ex(C_FRZ, 0, 0, 2'b00));
    step("mw_w1", req_br, ex(C_FRZ, 0, 0, 2'b00));
    step("mw_w2", req_br, ex(C_FRZ, 0, 0, 2'b00));
    step("mw_exit", req_br_rdy, ex(C_BR, 0, 0, 2'b00));
    step("mw_after", idle, ex(C_RUN, 0, 0, 2'b00));

    for (int k = 0; k < 9; k++) begin
      step(tbl[k].name, tbl[k].i, ex(tbl[k].ctrl, 0, 0, 2'b00));
    end

    // Reset while frozen in MEM_WAIT.
    req_only = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    step("rw_run", req_only, ex(C_FRZ, 0, 0, 2'b00));
    step("rw_w1", req_only, ex(C_FRZ, 0, 0, 2'b00));
    apply(idle);
    reset_check("rst_in_wait");
    step("rw_back_run", idle, ex(C_RUN, 0, 0, 2'b00));

    // Timeout: four wait cycles, then sticky ERR.
    step("to_run", req_only, ex(C_FRZ, 0, 0, 2'b00));
    for (int k = 1; k <= 4; k++) begin
      step($sformatf("to_w%0d", k), req_only, ex(C_FRZ, 0, 0, 2'b00));
    end
    step("err1", req_only, ex(C_FRZ, 1, 0, 2'b00));
    step("err_rdy", mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1), ex(C_FRZ, 1, 0, 2'b00));
    step("err_idle", idle, ex(C_FRZ, 1, 0, 2'b00));
    apply(idle);
    reset_check("rst_from_err");
    step("err_cleared", idle, ex(C_RUN, 0, 0, 2'b00));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
Central pipeline controller for the 5-stage MIPS core. It watches register use in ID, destinations in EXE and MEM, branch resolution in EXE, and the data-memory handshake. From these it drives the stage-register enables, flushes and bubbles so the IF/ID/EXE/MEM/WB datapath runs hazard-free. It also keeps a stall counter and a sticky memory-timeout error.

Parameters:
MEM_TIMEOUT, 64, max cycles MEM_WAIT may last before entering ERR (1..65535)
STALL_CNT_W, 16, width of the saturating stall-cycle counter

Ports:
clk  in  1  clock, all flops on posedge
rst  in  1  asynchronous, active-low reset
id_src1  in  5  rs of instruction in ID (Instruction[25:21])
id_src2  in  5  rt of instruction in ID (Instruction[20:16])
id_src2_used  in  1  ID instruction reads rt (R-type, store, bne)
exe_dest  in  5  Dest held in ID/EXE register
exe_wb_en  in  1  WB_EN held in ID/EXE register
exe_mem_r_en  in  1  MEM_R_EN held in ID/EXE register (load in EXE)
mem_dest  in  5  Dest held in EXE/MEM register
mem_wb_en  in  1  WB_EN held in EXE/MEM register
br_taken  in  1  branch taken, resolved in EXE
mem_req  in  1  MEM stage performing load/store this cycle
mem_ready  in  1  data memory completes access this cycle
pc_en  out  1  PC register load enable
ifid_en  out  1  IF/ID register load enable
ifid_flush  out  1  clear IF/ID register
idex_bubble  out  1  load ID/EXE with all-zero control (NOP)
back_en  out  1  enable for ID/EXE, EXE/MEM, MEM/WB registers
mem_err  out  1  sticky, memory timeout occurred
stall_cnt  out  STALL_CNT_W  saturating count of cycles with pc_en=0
fwd_a  out  2  operand-1 forward select (FORWARDING_EN only)
fwd_b  out  2  operand-2 forward select (FORWARDING_EN only)

Behaviour:
- FSM states: RUN, MEM_WAIT, ERR. Register $0 never causes a hazard.
- Reset (rst=0, async): state=RUN, wait counter=0, stall_cnt=0, mem_err=0, fwd_a=fwd_b=00. While rst=0, outputs are pc_en=ifid_en=back_en=0 and ifid_flush=idex_bubble=1.
- RUN, priority from highest to lowest:
  1. mem_req & !mem_ready: all enables=0, no flush, next=MEM_WAIT, wait counter=1.
  2. br_taken: pc_en=ifid_en=back_en=1, ifid_flush=1, idex_bubble=1.
  3. raw_hazard: pc_en=ifid_en=0, back_en=1, idex_bubble=1, ifid_flush=0.
  4. Otherwise: pc_en=ifid_en=back_en=1, no flush or bubble.
- raw_hazard without the feature is true when:
  - (exe_wb_en & exe_dest==src) or (mem_wb_en & mem_dest==src),
  - for src=id_src1, and for src=id_src2 when id_src2_used.
  The WB-stage case is resolved by the register file (write-before-read).
- MEM_WAIT: all enables=0, no flush or bubble, wait counter increments.
  - If mem_ready: next=RUN and the counter clears. That cycle's outputs follow the RUN rules 2-4, so a branch held in EXE during the wait is acted on at exit.
  - If the counter reaches MEM_TIMEOUT with no mem_ready: next=ERR.
- ERR: all enables=0, mem_err=1. Held until reset.
- stall_cnt increments on every post-reset cycle with pc_en=0 and saturates at all-ones.
- All outputs except stall_cnt, mem_err and fwd_* are combinational from state and inputs. There are no combinational paths from mem_ready to state.

Optional Feature:
- Macro: HAZARD_CTRL_FORWARDING_EN.
- Defined:
  - raw_hazard reduces to load-use only: exe_wb_en & exe_mem_r_en & exe_dest matches a used source.
  - fwd_a/fwd_b are registered and loaded whenever ID/EXE loads (back_en=1).
  - Encoding per operand: 01 when exe_wb_en & !exe_mem_r_en & exe_dest==src (EXE/MEM ALU result); else 10 when mem_wb_en & mem_dest==src (MEM/WB write value); else 00.
  - Loaded as 00 on an idex_bubble, and held when back_en=0.
- Undefined: fwd_a/fwd_b are tied 00 and the full RAW stall rule applies.

Decomposition:
- Package hazard_ctrl_pkg holds:
  - state enum (RUN, MEM_WAIT, ERR);
  - FWD_NONE=00, FWD_EXE=01, FWD_MEM=10;
  - REG_ZERO=5'd0.
- Sub-module hazard_cmp: combinational dest-vs-src match (wb_en, dest, src, src_used) that excludes $0. It is instantiated four times.

Test Plan:
- rst low mid-MEM_WAIT → state RUN, stall_cnt=0; with rst low, outputs are pc_en=0, idex_bubble=1.
- ID add reads r5, EXE has wb_en dest=5 (no feature) → 2 cycles pc_en=0 and idex_bubble=1, then pc_en=1; stall_cnt=2.
- Same stimulus with the feature → no stall, fwd_a=01. Load to r5 in EXE plus a use of r5 in ID → exactly 1 bubble, then fwd_a=10.
- mem_req=1, mem_ready after 3 cycles, br_taken=1 throughout → 3 frozen cycles, then ifid_flush=idex_bubble=1 on the exit cycle.
- MEM_TIMEOUT=4, mem_req=1, mem_ready=0 forever → ERR after 4 wait cycles, mem_err=1 sticky; pc_en stays 0 until reset.
- ID src=0, EXE dest=0 with wb_en=1 → no stall.
